// File: rtl/bp_update_ctrl_pkg.sv
// rtl/bp_update_ctrl_pkg.sv - shared widths, state encoding and update record for the BTB write sequencer
//
// Purpose : common definitions imported by bp_update_ctrl and bp_update_ctrl_fifo.
// Contents: BTB geometry, update queue depth, starvation limit, FSM state type,
//           packed branch-update record (index, direction, target).
package bp_update_ctrl_pkg;

    localparam int IDX_W      = 6;
    localparam int ENTRIES    = 64;
    localparam int TGT_W      = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_LIM = 8;
    localparam int STARVE_W   = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [TGT_W-1:0] target;
    } upd_t;

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// rtl/bp_update_ctrl_fifo.sv - branch-update queue with per-entry live bit, tail coalesce and kill-by-index
//
// Purpose : holds resolved-branch updates from EX until the controller grants the BTB write port.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           push/push_data enqueue an update (coalesces into a live tail with the same index)
//           pop            drop the head entry (granted or dead)
//           flush          empty the queue, overrides push/pop
//           kill/kill_idx  mark every queued entry with this index dead; a same-cycle push
//                          with this index enters dead
//           head/head_live current head record and whether it must still be written
//           empty/full     occupancy flags
module bp_update_ctrl_fifo
    import bp_update_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  upd_t             push_data,
    input  logic             pop,
    input  logic             flush,
    input  logic             kill,
    input  logic [IDX_W-1:0] kill_idx,
    output upd_t             head,
    output logic             head_live,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    upd_t             mem [DEPTH];
    logic [DEPTH-1:0] live;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] push_ptr;
    logic [CNT_W-1:0] count;
    logic             coalesce;
    logic             push_live;
    logic             grow;

    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign head     = mem[rd_ptr];
    assign head_live = !empty && live[rd_ptr];

    // A lone entry leaving this cycle cannot absorb the new update, or the
    // new data would vanish with the pop.
    assign coalesce = push && !empty && live[tail_ptr]
                    && (mem[tail_ptr].idx == push_data.idx)
                    && !(pop && (count == CNT_W'(1)));
    assign push_live = !(kill && (push_data.idx == kill_idx));
    assign push_ptr  = coalesce ? tail_ptr : wr_ptr;
    assign grow      = push && !coalesce;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else begin
            // Kill first; pop and push below override the bits they own.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && (mem[i].idx == kill_idx)) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                live[push_ptr] <= push_live;
            end
            if (grow) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({grow, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[push_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - sole owner of the IF1 BTB write port: init clear, EX updates, invalidates
//
// Purpose : clears the BTB after reset, queues EX branch updates and arbitrates them against
//           single-index and whole-table invalidates, one BTB write per cycle, all registered.
// Ports   : clk, rst_n                       clock, asynchronous active-low reset
//           ex_upd_valid/ready/idx/taken/target  EX update handshake and payload
//           inv_req/inv_all/inv_idx/inv_ack      invalidate request (held until ack) and ack pulse
//           btb_we/clr/waddr/wtaken/wtarget      BTB write port
//           init_done                            low during the post-reset clear sweep
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_upd_valid,
    output logic             ex_upd_ready,
    input  logic [IDX_W-1:0] ex_upd_idx,
    input  logic             ex_upd_taken,
    input  logic [TGT_W-1:0] ex_upd_target,
    input  logic             inv_req,
    input  logic             inv_all,
    input  logic [IDX_W-1:0] inv_idx,
    output logic             inv_ack,
    output logic             btb_we,
    output logic             btb_clr,
    output logic [IDX_W-1:0] btb_waddr,
    output logic             btb_wtaken,
    output logic [TGT_W-1:0] btb_wtarget,
    output logic             init_done
);

    state_t            state;
    logic [IDX_W-1:0]  sweep_cnt;
    logic [STARVE_W-1:0] starve;

    upd_t head;
    upd_t push_data;
    logic head_live;
    logic empty;
    logic full;

    logic is_run;
    logic forced;
    logic inv_go;
    logic head_go;
    logic dead_pop;
    logic flush;
    logic kill;
    logic push;
    logic pop;
    logic last_idx;

    assign push_data = '{idx: ex_upd_idx, taken: ex_upd_taken, target: ex_upd_target};

    assign is_run       = (state == ST_RUN);
    assign ex_upd_ready = is_run && !full;
    assign last_idx     = (sweep_cnt == IDX_W'(ENTRIES - 1));

    // A long-starved live head outranks invalidates; otherwise invalidates win.
    // A dead head is popped on the side and never uses the write port.
    assign forced   = is_run && head_live && (starve >= STARVE_W'(STARVE_LIM));
    assign inv_go   = is_run && inv_req && !forced;
    assign head_go  = is_run && head_live && !inv_go;
    assign dead_pop = is_run && !empty && !head_live;
    assign flush    = inv_go && inv_all;
    assign kill     = inv_go && !inv_all;
    assign pop      = head_go || dead_pop;
    assign push     = ex_upd_valid && ex_upd_ready && !flush;

    bp_update_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .kill      (kill),
        .kill_idx  (inv_idx),
        .head      (head),
        .head_live (head_live),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            sweep_cnt   <= '0;
            starve      <= '0;
            inv_ack     <= 1'b0;
            btb_we      <= 1'b0;
            btb_clr     <= 1'b0;
            btb_waddr   <= '0;
            btb_wtaken  <= 1'b0;
            btb_wtarget <= '0;
            init_done   <= 1'b0;
        end else begin
            btb_we      <= 1'b0;
            btb_clr     <= 1'b0;
            btb_waddr   <= '0;
            btb_wtaken  <= 1'b0;
            btb_wtarget <= '0;
            inv_ack     <= 1'b0;
            case (state)
                ST_INIT: begin
                    btb_we    <= 1'b1;
                    btb_clr   <= 1'b1;
                    btb_waddr <= sweep_cnt;
                    sweep_cnt <= sweep_cnt + IDX_W'(1);
                    starve    <= '0;
                    if (last_idx) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    btb_we    <= 1'b1;
                    btb_clr   <= 1'b1;
                    btb_waddr <= sweep_cnt;
                    sweep_cnt <= sweep_cnt + IDX_W'(1);
                    starve    <= '0;
                    if (last_idx) begin
                        state   <= ST_RUN;
                        inv_ack <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state     <= ST_SWEEP;
                        sweep_cnt <= '0;
                    end else if (inv_go) begin
                        btb_we    <= 1'b1;
                        btb_clr   <= 1'b1;
                        btb_waddr <= inv_idx;
                        inv_ack   <= 1'b1;
                    end else if (head_go) begin
                        btb_we      <= 1'b1;
                        btb_waddr   <= head.idx;
                        btb_wtaken  <= head.taken;
                        btb_wtarget <= head.target;
                    end
                    if (flush || empty || pop) begin
                        starve <= '0;
                    end else if (starve != STARVE_W'(STARVE_LIM)) begin
                        starve <= starve + STARVE_W'(1);
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - self-checking bench for bp_update_ctrl against a queue-based reference model
module tb_bp_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_upd_valid;
    logic        ex_upd_ready;
    logic [5:0]  ex_upd_idx;
    logic        ex_upd_taken;
    logic [31:0] ex_upd_target;
    logic        inv_req;
    logic        inv_all;
    logic [5:0]  inv_idx;
    logic        inv_ack;
    logic        btb_we;
    logic        btb_clr;
    logic [5:0]  btb_waddr;
    logic        btb_wtaken;
    logic [31:0] btb_wtarget;
    logic        init_done;

    bp_update_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_upd_valid  (ex_upd_valid),
        .ex_upd_ready  (ex_upd_ready),
        .ex_upd_idx    (ex_upd_idx),
        .ex_upd_taken  (ex_upd_taken),
        .ex_upd_target (ex_upd_target),
        .inv_req       (inv_req),
        .inv_all       (inv_all),
        .inv_idx       (inv_idx),
        .inv_ack       (inv_ack),
        .btb_we        (btb_we),
        .btb_clr       (btb_clr),
        .btb_waddr     (btb_waddr),
        .btb_wtaken    (btb_wtaken),
        .btb_wtarget   (btb_wtarget),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 = clearing after reset, 1 = serving, 2 = clearing for inv_all.
    typedef struct {
        int          idx;
        bit          taken;
        logic [31:0] tgt;
        bit          live;
    } ent_t;

    ent_t        q[$];
    int          m_mode;
    int          m_cnt;
    int          m_starve;
    bit          e_we, e_clr, e_tk, e_ack, e_done;
    logic [5:0]  e_addr;
    logic [31:0] e_tgt;

    int          wr_cnt[64];
    logic [31:0] wr_tgt[64];

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_cnt = 0; m_starve = 0;
        e_we = 0; e_clr = 0; e_tk = 0; e_ack = 0; e_done = 0;
        e_addr = '0; e_tgt = '0;
    endtask

    task automatic model_step();
        bit   has, hlive, force_h, inv_win, take_head, do_pop, acc;
        ent_t ne;
        ent_t t;
        e_we = 0; e_clr = 0; e_tk = 0; e_ack = 0; e_addr = '0; e_tgt = '0;
        if (m_mode != 1) begin
            e_we = 1; e_clr = 1; e_addr = 6'(m_cnt);
            if (m_cnt == 63) begin
                if (m_mode == 0) e_done = 1;
                else e_ack = 1;
                m_mode = 1;
            end
            m_cnt = (m_cnt + 1) % 64;
            m_starve = 0;
        end else begin
            has       = q.size() > 0;
            hlive     = has && q[0].live;
            force_h   = hlive && (m_starve >= 8);
            inv_win   = inv_req && !force_h;
            take_head = hlive && !inv_win;
            do_pop    = has && (!q[0].live || take_head);
            acc       = ex_upd_valid && (q.size() < 4);
            if (inv_win && inv_all) begin
                q.delete();
                m_mode = 2; m_cnt = 0; m_starve = 0;
            end else begin
                if (inv_win) begin
                    e_we = 1; e_clr = 1; e_addr = inv_idx; e_ack = 1;
                end else if (take_head) begin
                    e_we = 1; e_addr = 6'(q[0].idx); e_tk = q[0].taken; e_tgt = q[0].tgt;
                end
                if (!has || do_pop) m_starve = 0;
                else if (m_starve < 8) m_starve = m_starve + 1;
                if (do_pop) void'(q.pop_front());
                if (acc) begin
                    ne.idx = int'(ex_upd_idx); ne.taken = ex_upd_taken;
                    ne.tgt = ex_upd_target; ne.live = 1;
                    if (q.size() > 0 && q[q.size()-1].live && q[q.size()-1].idx == ne.idx)
                        q[q.size()-1] = ne;
                    else
                        q.push_back(ne);
                end
                if (inv_win) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].idx == int'(inv_idx)) begin
                            t = q[i]; t.live = 0; q[i] = t;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        bit m_ready;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        m_ready = (m_mode == 1) && (q.size() < 4);
        chk("btb", 64'({btb_we, btb_clr, btb_waddr, btb_wtaken, btb_wtarget}),
                   64'({e_we, e_clr, e_addr, e_tk, e_tgt}));
        chk("ctl", 64'({inv_ack, init_done, ex_upd_ready}), 64'({e_ack, e_done, m_ready}));
        if (btb_we && !btb_clr) begin
            wr_cnt[btb_waddr]++;
            wr_tgt[btb_waddr] = btb_wtarget;
        end
    endtask

    task automatic idle_inputs();
        ex_upd_valid = 0; ex_upd_idx = '0; ex_upd_taken = 0; ex_upd_target = '0;
        inv_req = 0; inv_all = 0; inv_idx = '0;
    endtask

    task automatic offer(input int idx, input bit tk, input logic [31:0] tgt);
        ex_upd_valid = 1; ex_upd_idx = 6'(idx); ex_upd_taken = tk; ex_upd_target = tgt;
    endtask

    initial begin
        int  waited;
        bit  got_ack;
        n_run = 0; n_fail = 0;
        for (int i = 0; i < 64; i++) begin wr_cnt[i] = 0; wr_tgt[i] = '0; end
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (3) tick();
        rst_n = 1;

        // Post-reset clear of every entry
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("init_addr", 64'(btb_waddr), 64'(i));
            if (i < 63) chk("init_done_lo", 64'(init_done), 64'(0));
        end
        tick();
        chk("init_done_hi", 64'(init_done), 64'(1));

        // Single update reaches the BTB one cycle after acceptance
        offer(5, 1, 32'h1c000040);
        tick();
        ex_upd_valid = 0;
        tick();
        chk("upd5_we", 64'({btb_we, btb_clr}), 64'(2'b10));
        chk("upd5_addr", 64'(btb_waddr), 64'(5));
        chk("upd5_data", 64'({btb_wtaken, btb_wtarget}), 64'({1'b1, 32'h1c000040}));
        repeat (2) tick();

        // Two updates to idx 3 coalesce while invalidates hold the port
        inv_req = 1; inv_idx = 6'd40;
        offer(3, 0, 32'hAAAA0000);
        tick();
        offer(3, 1, 32'hBBBB0000);
        tick();
        ex_upd_valid = 0;
        repeat (2) tick();
        inv_req = 0;
        repeat (4) tick();
        chk("coal_cnt", 64'(wr_cnt[3]), 64'(1));
        chk("coal_tgt", 64'(wr_tgt[3]), 64'(32'hBBBB0000));

        // Invalidate kills a queued update to the same index
        inv_req = 1; inv_idx = 6'd40;
        offer(7, 1, 32'h7777);
        tick();
        offer(9, 1, 32'h9999);
        tick();
        ex_upd_valid = 0; inv_idx = 6'd7;
        tick();
        chk("kill_ack", 64'({inv_ack, btb_clr, btb_waddr}), 64'({1'b1, 1'b1, 6'd7}));
        inv_req = 0;
        repeat (4) tick();
        chk("kill_7", 64'(wr_cnt[7]), 64'(0));
        chk("kill_9", 64'(wr_cnt[9]), 64'(1));

        // Starvation: a queued update is forced through a continuous invalidate stream
        inv_req = 1; inv_idx = 6'($urandom_range(32, 63));
        offer(11, 0, 32'h1111);
        tick();
        ex_upd_valid = 0;
        for (int i = 0; i < 9; i++) begin
            inv_idx = 6'($urandom_range(32, 63));
            tick();
        end
        chk("starve_force", 64'(wr_cnt[11]), 64'(1));
        for (int i = 0; i < 4; i++) begin
            inv_idx = 6'($urandom_range(32, 63));
            offer(20 + i, i[0], 32'(i) + 32'h2000);
            tick();
        end
        ex_upd_valid = 0;
        chk("full_ready", 64'(ex_upd_ready), 64'(0));
        inv_req = 0;
        repeat (8) tick();
        chk("full_drain", 64'(wr_cnt[20] + wr_cnt[21] + wr_cnt[22] + wr_cnt[23]), 64'(4));

        // inv_all with three queued updates: flush and full sweep
        inv_req = 1; inv_idx = 6'd50;
        for (int i = 0; i < 3; i++) begin
            offer(12 + i, 1, 32'h3000 + 32'(i));
            tick();
        end
        ex_upd_valid = 0; inv_all = 1;
        got_ack = 0;
        waited = 0;
        while (!got_ack && waited < 80) begin
            tick();
            waited++;
            if (inv_ack) begin
                got_ack = 1;
                chk("sweep_last", 64'({btb_clr, btb_waddr}), 64'({1'b1, 6'd63}));
            end
        end
        chk("sweep_ack", 64'(got_ack), 64'(1));
        inv_req = 0; inv_all = 0;
        repeat (6) tick();
        chk("flush_drop", 64'(wr_cnt[12] + wr_cnt[13] + wr_cnt[14]), 64'(0));

        // Randomized traffic; invalidates held until acknowledged
        for (int c = 0; c < 700; c++) begin
            ex_upd_valid  = ($urandom_range(0, 2) != 0);
            ex_upd_idx    = 6'($urandom_range(0, 7));
            ex_upd_taken  = 1'($urandom_range(0, 1));
            ex_upd_target = $urandom;
            if (!inv_req && $urandom_range(0, 3) == 0) begin
                inv_req = 1;
                inv_all = ($urandom_range(0, 39) == 0);
                inv_idx = 6'($urandom_range(0, 7));
            end
            tick();
            if (e_ack) begin inv_req = 0; inv_all = 0; end
        end
        idle_inputs();
        repeat (4) tick();

        // Reset in the middle of a sweep restarts the clear from index 0
        inv_req = 1; inv_all = 1;
        repeat (10) tick();
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_btb", 64'({btb_we, btb_clr, btb_waddr, btb_wtaken, btb_wtarget}), 64'(0));
        chk("rst_ctl", 64'({inv_ack, init_done, ex_upd_ready}), 64'(0));
        idle_inputs();
        repeat (2) tick();
        rst_n = 1;
        tick();
        chk("reinit_first", 64'({btb_we, btb_clr, btb_waddr}), 64'({1'b1, 1'b1, 6'd0}));
        repeat (66) tick();
        chk("reinit_done", 64'(init_done), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
